tile_sequencer: RTL
===================

Name: tile_sequencer

Overview:
- Sits directly upstream of the GPU tile controller and drives its per-tile control inputs: start_row, start_col, pixel_buffer, do_render and clear_interrupt.
- One host start renders a full frame. The block walks all MY_ROWS x MY_COLS tiles in row-major order. Each tile is handed to the controller, the block waits for the controller's irq, acknowledges it, then advances.
- After the last tile it raises a single frame-level interrupt to the host.
- A watchdog aborts the frame if a tile never completes.

Parameters:
- TOTAL_ROWS, 120, frame height in pixels; must be a multiple of MY_ROWS.
- TOTAL_COLS, 160, frame width in pixels; must be a multiple of MY_COLS.
- MY_ROWS, 8, tile height (rows per controller pass).
- MY_COLS, 8, tile width.
- PIXEL_BITS, 8, width of start_row/start_col.
- TIMEOUT_CYCLES, 1048576, maximum cycles in WAIT before abort; 0 disables the watchdog.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  host pulse to begin a frame; ignored unless idle.
- frame_buffer  in  32  host byte address of pixel output for tile 0; sampled on accepted start.
- busy  out  1  high from accepted start until return to IDLE.
- frame_irq  out  1  frame-complete interrupt, level, held until clear_irq.
- error  out  1  watchdog abort flag; cleared on next accepted start.
- clear_irq  in  1  host acknowledge of frame_irq.
- tiles_done  out  16  tiles completed in the current frame.
- start_row  out  PIXEL_BITS  top row of current tile to the controller.
- start_col  out  PIXEL_BITS  left column of current tile to the controller.
- pixel_buffer  out  32  byte address for current tile's pixel writeout.
- do_render  out  1  one-cycle render request to the controller.
- ctrl_irq  in  1  controller tile-complete irq.
- clear_interrupt  out  1  one-cycle acknowledge to the controller.

Behaviour:
- Reset values: all outputs and counters are 0; state is IDLE.
- Derived constants:
  - TILE_PIXELS = MY_ROWS*MY_COLS.
  - TILES_X = TOTAL_COLS/MY_COLS.
  - TILES_Y = TOTAL_ROWS/MY_ROWS.
- IDLE: busy=0.
  - start=1 -> latch pixel_buffer<=frame_buffer; start_row<=0, start_col<=0; tiles_done<=0; error<=0; busy<=1 -> ISSUE.
- ISSUE: do_render=1 for exactly this cycle; watchdog count<=0 -> WAIT.
- WAIT: stay while ctrl_irq=0; count increments each cycle.
  - ctrl_irq=1 -> ACK.
  - If TIMEOUT_CYCLES!=0 and count reaches TIMEOUT_CYCLES-1 with ctrl_irq still 0 -> error<=1, frame_irq<=1 -> DONE. If ctrl_irq=1 in that same cycle, completion wins: go to ACK, no error.
- ACK: clear_interrupt=1 for exactly this cycle; tiles_done<=tiles_done+1 -> DRAIN.
- DRAIN: wait for ctrl_irq=0, which guarantees the controller is back in its idle state. Then:
  - if last tile (tiles_done==TILES_X*TILES_Y) -> frame_irq<=1 -> DONE;
  - else advance and go to ISSUE.
- Advance rule:
  - pixel_buffer<=pixel_buffer+TILE_PIXELS.
  - If start_col==TOTAL_COLS-MY_COLS: start_col<=0, start_row<=start_row+MY_ROWS.
  - Otherwise start_col<=start_col+MY_COLS.
- DONE: frame_irq=1, busy=1.
  - clear_irq=1 -> frame_irq<=0, busy<=0 -> IDLE.
  - start in DONE is ignored.
- Output stability: start_row, start_col and pixel_buffer are registered and stable from the ISSUE cycle through DRAIN. They change only on the advance edge.
- Arithmetic: pixel_buffer is 32-bit and wraps modulo 2^32 with no flag.
- Minimum per-tile overhead: ISSUE+ACK+DRAIN = 3 cycles plus controller latency; do_render never reasserts before ctrl_irq has fallen.
- Reset mid-frame returns to IDLE within one cycle. The controller must share the same reset; no partial-frame state is preserved.
- start asserted together with reset: reset wins.

Test Plan (TOTAL_ROWS=16, TOTAL_COLS=16, MY_ROWS=MY_COLS=8, TIMEOUT_CYCLES=64; controller model raises irq 10 cycles after do_render and drops it 1 cycle after clear_interrupt):
- Frame run, start with frame_buffer=0x1000 -> exactly 4 do_render pulses with (row,col,pixel_buffer) = (0,0,0x1000), (0,8,0x1040), (8,0,0x1080), (8,8,0x10C0). Then frame_irq=1, tiles_done=4, error=0.
- Host acknowledge: clear_irq pulse in DONE -> next cycle frame_irq=0, busy=0. A second start then repeats the sequence from (0,0).
- Start while busy: start pulsed during tile 2 WAIT -> ignored; sequence unchanged, still 4 tiles.
- Slow irq drop: controller model holds irq 5 extra cycles after clear_interrupt -> block stays in DRAIN, no early do_render; outputs stable throughout.
- Watchdog: model never raises irq on tile 3 -> after 64 WAIT cycles error=1, frame_irq=1, tiles_done=2; the next start clears error.
- Mid-frame reset: reset during tile 2 WAIT -> next cycle all outputs 0, state IDLE; a subsequent start restarts at (0,0,frame_buffer).

Source files
------------

// File: rtl/tile_sequencer.sv
// -----------------------------------------------------------------------------
// tile_sequencer
//
// Walks a frame of TOTAL_ROWS x TOTAL_COLS pixels in row-major tiles of
// MY_ROWS x MY_COLS. For each tile it hands the tile origin and pixel
// destination address to the downstream tile controller, waits for the
// controller's completion irq, acknowledges it, waits for the irq to fall,
// then advances. After the last tile a level frame interrupt is raised to
// the host. A watchdog aborts the frame if a tile never completes.
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   start            host request to begin a frame (accepted only when idle)
//   frame_buffer     host byte address of tile 0 output, sampled on start
//   busy             high from accepted start until return to idle
//   frame_irq        frame-complete interrupt, held until clear_irq
//   error            watchdog abort flag, cleared on next accepted start
//   clear_irq        host acknowledge of frame_irq
//   tiles_done       tiles completed in the current frame
//   start_row/col    origin of the current tile, to the controller
//   pixel_buffer     byte address of the current tile's writeout
//   do_render        one-cycle render request to the controller
//   ctrl_irq         controller tile-complete irq
//   clear_interrupt  one-cycle acknowledge to the controller
// -----------------------------------------------------------------------------
module tile_sequencer #(
    parameter int TOTAL_ROWS     = 120,
    parameter int TOTAL_COLS     = 160,
    parameter int MY_ROWS        = 8,
    parameter int MY_COLS        = 8,
    parameter int PIXEL_BITS     = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           frame_buffer,
    output logic                  busy,
    output logic                  frame_irq,
    output logic                  error,
    input  logic                  clear_irq,
    output logic [15:0]           tiles_done,
    output logic [PIXEL_BITS-1:0] start_row,
    output logic [PIXEL_BITS-1:0] start_col,
    output logic [31:0]           pixel_buffer,
    output logic                  do_render,
    input  logic                  ctrl_irq,
    output logic                  clear_interrupt
);

    localparam int TILE_PIXELS = MY_ROWS * MY_COLS;
    localparam int TILES_X     = TOTAL_COLS / MY_COLS;
    localparam int TILES_Y     = TOTAL_ROWS / MY_ROWS;
    localparam int TILES_TOTAL = TILES_X * TILES_Y;

    // Watchdog counter only has to reach TIMEOUT_CYCLES-1.
    localparam bit WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam int WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [PIXEL_BITS-1:0] LAST_COL  = PIXEL_BITS'(TOTAL_COLS - MY_COLS);
    localparam logic [PIXEL_BITS-1:0] ROW_STEP  = PIXEL_BITS'(MY_ROWS);
    localparam logic [PIXEL_BITS-1:0] COL_STEP  = PIXEL_BITS'(MY_COLS);
    localparam logic [31:0]           ADDR_STEP = 32'(TILE_PIXELS);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WD_W-1:0] wd_count;
    logic            wd_expire;
    logic            last_tile;

    assign wd_expire = WD_EN && (wd_count == WD_W'(WD_LAST));
    // tiles_done has already been bumped in ACK, so it equals the total
    // while draining the final tile.
    assign last_tile = (tiles_done == 16'(TILES_TOTAL));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others; blocking here would make the
    // result depend on statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here is given a default first, so no path
    // through the case statement leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next      = state;
        do_render       = 1'b0;
        clear_interrupt = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                do_render  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // Completion takes priority over a simultaneous timeout.
                if (ctrl_irq) begin
                    state_next = ACK;
                end else if (wd_expire) begin
                    state_next = DONE;
                end
            end
            ACK: begin
                clear_interrupt = 1'b1;
                state_next      = DRAIN;
            end
            DRAIN: begin
                // A low irq means the controller is idle again, so the next
                // render request cannot overlap the previous tile.
                if (!ctrl_irq) begin
                    state_next = last_tile ? DONE : ISSUE;
                end
            end
            DONE: begin
                if (clear_irq) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and the host-facing level outputs. busy and frame_irq are
    // registered rather than decoded from state so the host sees clean levels.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy         <= 1'b0;
            frame_irq    <= 1'b0;
            error        <= 1'b0;
            tiles_done   <= '0;
            start_row    <= '0;
            start_col    <= '0;
            pixel_buffer <= '0;
            wd_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        error        <= 1'b0;
                        tiles_done   <= '0;
                        start_row    <= '0;
                        start_col    <= '0;
                        pixel_buffer <= frame_buffer;
                    end
                end
                ISSUE: begin
                    wd_count <= '0;
                end
                WAIT: begin
                    wd_count <= wd_count + WD_W'(1);
                    if (!ctrl_irq && wd_expire) begin
                        error     <= 1'b1;
                        frame_irq <= 1'b1;
                    end
                end
                ACK: begin
                    tiles_done <= tiles_done + 16'd1;
                end
                DRAIN: begin
                    if (!ctrl_irq) begin
                        if (last_tile) begin
                            frame_irq <= 1'b1;
                        end else begin
                            // Tile origin and address only move here, so
                            // they hold steady from ISSUE through DRAIN.
                            pixel_buffer <= pixel_buffer + ADDR_STEP;
                            if (start_col == LAST_COL) begin
                                start_col <= '0;
                                start_row <= start_row + ROW_STEP;
                            end else begin
                                start_col <= start_col + COL_STEP;
                            end
                        end
                    end
                end
                DONE: begin
                    if (clear_irq) begin
                        frame_irq <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
